mult_iter_core: RTL and testbench

MULT_ITER_CORE -- requirements
Module: mult_iter_core

---
 rtl/fp_mul_pkg.sv | 26 ++
 rtl/mult_exp_add.sv | 31 +++
 rtl/mult_iter_core.sv | 126 ++++++++++++
 tb/tb_mult_iter_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared floating-point multiplier definitions: format defaults, product width
// and FSM state encoding, reused by the iterative core and the normaliser stage.
package fp_mul_pkg;

    localparam int unsigned EXP_WIDTH_DEF  = 8;
    localparam int unsigned MANT_WIDTH_DEF = 23;

    function automatic int unsigned bias_of(input int unsigned exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    // Raw significand product: two (MANT_WIDTH+1)-bit significands.
    function automatic int unsigned prod_width(input int unsigned mant_width);
        return 2 * mant_width + 2;
    endfunction

    localparam int unsigned BIAS_DEF       = bias_of(EXP_WIDTH_DEF);
    localparam int unsigned PROD_WIDTH_DEF = prod_width(MANT_WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_exp_add.sv
// Combinational exponent path: biased add, bias removal and range flags
// ahead of normalisation (the normaliser's possible +1 is not included).
module mult_exp_add
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int unsigned BIAS      = bias_of(EXP_WIDTH)
) (
    input  logic [EXP_WIDTH-1:0] exp_a,
    input  logic [EXP_WIDTH-1:0] exp_b,
    output logic [EXP_WIDTH-1:0] exp_sum,
    output logic                 exp_ovf,
    output logic                 exp_unf
);

    localparam int unsigned SUM_W = EXP_WIDTH + 2;

    localparam logic signed [SUM_W-1:0] BIAS_S  = SUM_W'(BIAS);
    localparam logic signed [SUM_W-1:0] OVF_LIM = SUM_W'((1 << EXP_WIDTH) - 1);
    localparam logic signed [SUM_W-1:0] ZERO_S  = '0;

    logic signed [SUM_W-1:0] exp_full;

    always_comb begin
        exp_full = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
        exp_sum  = exp_full[EXP_WIDTH-1:0];
        exp_ovf  = (exp_full >= OVF_LIM);
        exp_unf  = (exp_full <= ZERO_S);
    end

endmodule

// File: rtl/mult_iter_core.sv
// Iterative radix-2 shift-add significand multiplier, one multiplier bit per
// cycle, with sign and exponent results captured when the operation starts.
module mult_iter_core
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = EXP_WIDTH_DEF,
    parameter int unsigned MANT_WIDTH = MANT_WIDTH_DEF,
    parameter int unsigned BIAS       = bias_of(EXP_WIDTH)
) (
    input  logic                      in_Clk,
    input  logic                      in_Rst_n,
    input  logic                      in_SignA,
    input  logic                      in_SignB,
    input  logic [EXP_WIDTH-1:0]      in_ExpA,
    input  logic [EXP_WIDTH-1:0]      in_ExpB,
    input  logic [MANT_WIDTH-1:0]     in_MantA,
    input  logic [MANT_WIDTH-1:0]     in_MantB,
    input  logic                      in_Start,
    output logic                      out_Busy,
    output logic                      out_Done,
    output logic                      out_Sign,
    output logic [EXP_WIDTH-1:0]      out_Exp,
    output logic [2*MANT_WIDTH+1:0]   out_Mant,
    output logic                      out_ExpOvf,
    output logic                      out_ExpUnf
);

    localparam int unsigned SIG_W = MANT_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(SIG_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SIG_W - 1);

    mult_state_e state, state_nxt;

    logic [CNT_W-1:0]     iter_cnt;
    logic [SIG_W-1:0]     mcand;
    logic [SIG_W-1:0]     prod_hi;
    logic [SIG_W-1:0]     prod_lo;
    logic [SIG_W:0]       partial;
    logic                 sign_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic                 ovf_q;
    logic                 unf_q;

    logic [EXP_WIDTH-1:0] exp_sum;
    logic                 exp_ovf;
    logic                 exp_unf;

    mult_exp_add #(
        .EXP_WIDTH (EXP_WIDTH),
        .BIAS      (BIAS)
    ) u_exp_add (
        .exp_a   (in_ExpA),
        .exp_b   (in_ExpB),
        .exp_sum (exp_sum),
        .exp_ovf (exp_ovf),
        .exp_unf (exp_unf)
    );

    always_ff @(posedge in_Clk) begin
        if (!in_Rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        out_Busy  = 1'b0;
        out_Done  = 1'b0;
        case (state)
            IDLE: if (in_Start) state_nxt = MULT;
            MULT: begin
                out_Busy = 1'b1;
                if (iter_cnt == LAST_ITER) state_nxt = DONE;
            end
            DONE: begin
                out_Busy  = 1'b1;
                out_Done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplier bits are consumed from prod_lo while the product shifts in
    // from the top, so {prod_hi, prod_lo} is the full product after SIG_W steps.
    always_comb begin
        partial = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge in_Clk) begin
        if (!in_Rst_n) begin
            iter_cnt <= '0;
            mcand    <= '0;
            prod_hi  <= '0;
            prod_lo  <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_Start) begin
                    mcand    <= {1'b1, in_MantA};
                    prod_hi  <= '0;
                    prod_lo  <= {1'b1, in_MantB};
                    iter_cnt <= '0;
                    sign_q   <= in_SignA ^ in_SignB;
                    exp_q    <= exp_sum;
                    ovf_q    <= exp_ovf;
                    unf_q    <= exp_unf;
                end
                MULT: begin
                    {prod_hi, prod_lo} <= {partial, prod_lo[SIG_W-1:1]};
                    iter_cnt           <= iter_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_Sign   = sign_q;
    assign out_Exp    = exp_q;
    assign out_Mant   = {prod_hi, prod_lo};
    assign out_ExpOvf = ovf_q;
    assign out_ExpUnf = unf_q;

endmodule

// File: tb/tb_mult_iter_core.sv
// Directed bench for mult_iter_core: scoreboarded results, latency, handshake
// throughput and reset behaviour at the default single-precision format.
`timescale 1ns/1ps
module tb_mult_iter_core;

    localparam int unsigned EW = 8;
    localparam int unsigned MW = 23;
    localparam int          BIAS_TB = 127;

    logic            in_Clk = 1'b0;
    logic            in_Rst_n;
    logic            in_SignA, in_SignB;
    logic [EW-1:0]   in_ExpA, in_ExpB;
    logic [MW-1:0]   in_MantA, in_MantB;
    logic            in_Start;
    logic            out_Busy, out_Done, out_Sign;
    logic [EW-1:0]   out_Exp;
    logic [2*MW+1:0] out_Mant;
    logic            out_ExpOvf, out_ExpUnf;

    typedef struct {
        logic          sign;
        logic [EW-1:0] exp;
        logic [47:0]   mant;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_iter_core #(
        .EXP_WIDTH  (EW),
        .MANT_WIDTH (MW)
    ) dut (
        .in_Clk     (in_Clk),
        .in_Rst_n   (in_Rst_n),
        .in_SignA   (in_SignA),
        .in_SignB   (in_SignB),
        .in_ExpA    (in_ExpA),
        .in_ExpB    (in_ExpB),
        .in_MantA   (in_MantA),
        .in_MantB   (in_MantB),
        .in_Start   (in_Start),
        .out_Busy   (out_Busy),
        .out_Done   (out_Done),
        .out_Sign   (out_Sign),
        .out_Exp    (out_Exp),
        .out_Mant   (out_Mant),
        .out_ExpOvf (out_ExpOvf),
        .out_ExpUnf (out_ExpUnf)
    );

    always #5 in_Clk = ~in_Clk;

    function automatic exp_t model(input logic sa, input logic sb_i,
                                   input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                   input logic [MW-1:0] ma, input logic [MW-1:0] mb);
        exp_t r;
        int e;
        logic [47:0] a48, b48;
        e      = int'(ea) + int'(eb) - BIAS_TB;
        a48    = {24'd0, 1'b1, ma};
        b48    = {24'd0, 1'b1, mb};
        r.sign = sa ^ sb_i;
        r.exp  = e[EW-1:0];
        r.ovf  = (e >= 255);
        r.unf  = (e <= 0);
        r.mant = a48 * b48;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, "_sign"}, 64'(out_Sign),   64'(e.sign));
        chk({tag, "_exp"},  64'(out_Exp),    64'(e.exp));
        chk({tag, "_mant"}, 64'(out_Mant),   64'(e.mant));
        chk({tag, "_ovf"},  64'(out_ExpOvf), 64'(e.ovf));
        chk({tag, "_unf"},  64'(out_ExpUnf), 64'(e.unf));
    endtask

    task automatic pop_and_check(input string tag, output exp_t e);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            e = '{default: '0};
        end else begin
            e = sb.pop_front();
            chk_outputs(tag, e);
        end
    endtask

    task automatic set_ops(input logic sa, input logic sb_i,
                           input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                           input logic [MW-1:0] ma, input logic [MW-1:0] mb);
        in_SignA = sa;  in_SignB = sb_i;
        in_ExpA  = ea;  in_ExpB  = eb;
        in_MantA = ma;  in_MantB = mb;
    endtask

    // Called on a negedge; returns on the negedge after the DONE cycle.
    task automatic run_op(input string tag, input logic sa, input logic sb_i,
                          input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          input logic [MW-1:0] ma, input logic [MW-1:0] mb);
        int cyc;
        exp_t e;
        set_ops(sa, sb_i, ea, eb, ma, mb);
        in_Start = 1'b1;
        sb.push_back(model(sa, sb_i, ea, eb, ma, mb));
        @(negedge in_Clk);
        in_Start = 1'b0;
        cyc = 1;
        while (!out_Done && cyc < 40) begin
            @(negedge in_Clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd25);
        chk({tag, "_busy_done"}, 64'(out_Busy), 64'd1);
        pop_and_check(tag, e);
        @(negedge in_Clk);
        chk({tag, "_done_1cyc"}, 64'(out_Done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(out_Busy), 64'd0);
        chk({tag, "_hold_mant"}, 64'(out_Mant), 64'(e.mant));
        chk({tag, "_hold_exp"},  64'(out_Exp),  64'(e.exp));
    endtask

    initial begin
        int   last_done;
        int   n_done;
        exp_t e;

        in_Rst_n = 1'b0;
        in_Start = 1'b0;
        set_ops(1'b0, 1'b0, '0, '0, '0, '0);
        repeat (2) @(negedge in_Clk);
        chk("rst_busy", 64'(out_Busy), 64'd0);
        chk("rst_done", 64'(out_Done), 64'd0);
        chk("rst_outs", 64'({out_Sign, out_Exp, out_Mant, out_ExpOvf, out_ExpUnf}), 64'd0);
        in_Rst_n = 1'b1;
        @(negedge in_Clk);

        run_op("one",   1'b0, 1'b1, 8'd127, 8'd127, 23'h000000, 23'h000000);
        run_op("onep5", 1'b0, 1'b0, 8'd127, 8'd127, 23'h400000, 23'h400000);
        run_op("max",   1'b1, 1'b1, 8'd127, 8'd127, 23'h7FFFFF, 23'h7FFFFF);
        run_op("ovf",   1'b0, 1'b0, 8'd200, 8'd200, 23'h123456, 23'h654321);
        run_op("unf",   1'b1, 1'b0, 8'd10,  8'd10,  23'h000001, 23'h7FFFFE);
        run_op("edge_hi", 1'b0, 1'b0, 8'd190, 8'd191, 23'h0F0F0F, 23'h70F0F0);
        run_op("edge_lo", 1'b0, 1'b1, 8'd64,  8'd63,  23'h2AAAAA, 23'h555555);
        for (int i = 0; i < 3; i++) begin
            run_op("rand", 1'($urandom), 1'($urandom),
                   8'($urandom_range(64, 190)), 8'($urandom_range(64, 190)),
                   23'($urandom), 23'($urandom));
        end

        // Start held high; operands changed while busy must not leak in.
        set_ops(1'b1, 1'b0, 8'd130, 8'd120, 23'h3C0FFE, 23'h1BEEF0);
        sb.push_back(model(1'b1, 1'b0, 8'd130, 8'd120, 23'h3C0FFE, 23'h1BEEF0));
        in_Start  = 1'b1;
        last_done = -1;
        n_done    = 0;
        for (int c = 1; c <= 90; c++) begin
            @(negedge in_Clk);
            if (c == 1) begin
                set_ops(1'b0, 1'b0, 8'd100, 8'd140, 23'h7ABCDE, 23'h012345);
                sb.push_back(model(1'b0, 1'b0, 8'd100, 8'd140, 23'h7ABCDE, 23'h012345));
            end
            if (c == 27) begin
                set_ops(1'b1, 1'b1, 8'd150, 8'd90, 23'h000FFF, 23'h7FF000);
                sb.push_back(model(1'b1, 1'b1, 8'd150, 8'd90, 23'h000FFF, 23'h7FF000));
            end
            if (c == 53) in_Start = 1'b0;
            if (c == 26) chk("held_gap_busy", 64'(out_Busy), 64'd0);
            if (out_Done) begin
                pop_and_check("held", e);
                if (last_done >= 0) chk("held_period", 64'(c - last_done), 64'd26);
                last_done = c;
                n_done++;
            end
        end
        chk("held_count", 64'(n_done), 64'd3);
        chk("held_sb_drained", 64'(sb.size()), 64'd0);

        // Reset at iteration 10 discards the operation.
        set_ops(1'b1, 1'b0, 8'd130, 8'd131, 23'h2468AC, 23'h13579B);
        in_Start = 1'b1;
        @(negedge in_Clk);
        in_Start = 1'b0;
        repeat (9) @(negedge in_Clk);
        in_Rst_n = 1'b0;
        @(negedge in_Clk);
        in_Rst_n = 1'b1;
        chk("midrst_busy", 64'(out_Busy), 64'd0);
        chk("midrst_done", 64'(out_Done), 64'd0);
        chk("midrst_outs", 64'({out_Sign, out_Exp, out_Mant, out_ExpOvf, out_ExpUnf}), 64'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge in_Clk);
            if (out_Done) n_done++;
        end
        chk("midrst_no_done", 64'(n_done), 64'd0);

        // Start asserted together with reset is ignored.
        in_Rst_n = 1'b0;
        in_Start = 1'b1;
        @(negedge in_Clk);
        in_Rst_n = 1'b1;
        in_Start = 1'b0;
        chk("rst_start_ignored", 64'(out_Busy), 64'd0);
        @(negedge in_Clk);
        chk("rst_start_still_idle", 64'(out_Busy), 64'd0);

        run_op("post_rst", 1'b0, 1'b1, 8'd128, 8'd126, 23'h555555, 23'h2AAAAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
